// File: rtl/mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared definitions for the I/D cache memory bus arbiter:
//   - default burst length and starvation limit
//   - arbiter FSM state encoding
//   - burst owner encoding
//   - width helper used to size the beat and starvation counters
// ---------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

  // Default words per burst (power of two, >= 1).
  localparam int DEF_BEATS        = 4;
  // Default number of I-side wait cycles before it overrides the D-side.
  localparam int DEF_STARVE_LIMIT = 8;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } arb_state_t;

  // Which cache owns the current burst.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Bits needed to hold the values 0..max_val; never less than one bit so
  // degenerate parameters (BEATS=1, STARVE_LIMIT<=1) still give a legal vector.
  function automatic int width_for(input int max_val);
    if (max_val < 2) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// ---------------------------------------------------------------------------
// arb_starve_cnt
// Saturating wait counter for the I-side. Counts cycles in which the I-side
// is requesting but does not own the bus; clears when the I-side is granted.
// at_limit tells the arbiter the I-side has waited long enough to win over
// a concurrent D-side request.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   inc       in   I-side waiting this cycle
//   clr       in   I-side granted this cycle (wins over inc)
//   at_limit  out  count >= LIMIT
// ---------------------------------------------------------------------------
module arb_starve_cnt
  import mem_bus_arbiter_pkg::*;
#(
  parameter int LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int            CNT_W   = width_for(LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_W = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_reg;

  // Saturate at LIMIT: once reached, the compare stays true until a grant
  // clears it, and the counter can never wrap back below the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != LIMIT_W)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign at_limit = (cnt_reg >= LIMIT_W);

endmodule

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Arbitrates one burst memory port between an instruction-cache refill
// requester (read only) and a data-cache refill/writeback requester.
// The D-side normally wins; an I-side that has waited STARVE_LIMIT cycles
// wins instead. Each burst is an address phase (mem_req/mem_gnt) followed
// by BEATS data beats, then a one-cycle done pulse to the owner.
// A CSR flush request blocks new grants and reports when the bus is idle.
//
// Parameters:
//   BEATS         words per burst (power of two, >= 1)
//   STARVE_LIMIT  I-side wait cycles before it overrides the D-side
//
// Ports:
//   clk, rst_n                 clock / asynchronous active-low reset
//   ic_req, ic_addr            I-side request (held until ic_done), base addr
//   dc_req, dc_we, dc_addr     D-side request (held until dc_done), dir, addr
//   dc_wdata / dc_wready       D-side write beat data / beat accepted
//   rd_data                    read beat data shared by both sides
//   ic_rvalid / dc_rvalid      rd_data valid for that side
//   ic_done / dc_done          one-cycle burst-complete pulse
//   mem_req, mem_we, mem_addr  memory address phase (registered)
//   mem_gnt                    memory accepts the address phase
//   mem_wdata / mem_wvalid     write beat to memory
//   mem_wready                 memory accepts the write beat
//   mem_rdata / mem_rvalid     read beat from memory
//   flush_req / flush_done     block new grants / bus drained
// ---------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int BEATS        = DEF_BEATS,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        rst_n,
  // I-side
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_rvalid,
  output logic        ic_done,
  // D-side
  input  logic        dc_req,
  input  logic        dc_we,
  input  logic [31:0] dc_addr,
  input  logic [31:0] dc_wdata,
  output logic        dc_wready,
  output logic        dc_rvalid,
  output logic        dc_done,
  // shared read data
  output logic [31:0] rd_data,
  // memory side
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  output logic [31:0] mem_wdata,
  output logic        mem_wvalid,
  input  logic        mem_wready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  // flush
  input  logic        flush_req,
  output logic        flush_done
);

  localparam int                BEAT_W    = width_for(BEATS - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  arb_state_t        state_reg;
  owner_t            owner_reg;
  logic [BEAT_W-1:0] beat_reg;

  logic idle;
  logic grant_i;
  logic grant_d;
  logic starve_hit;
  logic i_busy;
  logic data_phase;
  logic read_phase;
  logic write_phase;
  logic beat_fire;
  logic last_beat;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  assign idle = (state_reg == ST_IDLE);

  // D-side has priority unless the I-side has been starved long enough.
  assign grant_i = idle && !flush_req && ic_req && (!dc_req || starve_hit);
  assign grant_d = idle && !flush_req && dc_req && !(ic_req && starve_hit);

  // The I-side only "waits" while somebody else holds the bus or it loses
  // arbitration; its own burst (ADDR..DONE) does not count.
  assign i_busy = !idle && (owner_reg == OWN_I);

  arb_starve_cnt #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (ic_req && !i_busy),
    .clr      (grant_i),
    .at_limit (starve_hit)
  );

  // -------------------------------------------------------------------------
  // Data-phase qualifiers. mem_we is held for the whole burst, so it also
  // selects the beat direction.
  // -------------------------------------------------------------------------
  assign data_phase  = (state_reg == ST_DATA);
  assign read_phase  = data_phase && !mem_we;
  assign write_phase = data_phase && mem_we;
  assign beat_fire   = write_phase ? mem_wready : (read_phase && mem_rvalid);
  assign last_beat   = (beat_reg == BEAT_LAST);

  // -------------------------------------------------------------------------
  // FSM with registered address-phase outputs and done pulses
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      owner_reg <= OWN_D;
      beat_reg  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      ic_done   <= 1'b0;
      dc_done   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_i || grant_d) begin
            state_reg <= ST_ADDR;
            owner_reg <= grant_i ? OWN_I : OWN_D;
            mem_addr  <= grant_i ? ic_addr : dc_addr;
            // The I-side is refill-only, so its direction is forced to read.
            mem_we    <= grant_i ? 1'b0 : dc_we;
            mem_req   <= 1'b1;
          end
        end

        ST_ADDR: begin
          if (mem_gnt) begin
            state_reg <= ST_DATA;
            mem_req   <= 1'b0;
            beat_reg  <= '0;
          end
        end

        ST_DATA: begin
          if (beat_fire) begin
            if (last_beat) begin
              state_reg <= ST_DONE;
              beat_reg  <= '0;
              ic_done   <= (owner_reg == OWN_I);
              dc_done   <= (owner_reg == OWN_D);
            end else begin
              beat_reg <= beat_reg + 1'b1;
            end
          end
        end

        ST_DONE: begin
          // Going back through IDLE gives the requester a cycle to drop its
          // req before it can be sampled again.
          state_reg <= ST_IDLE;
          ic_done   <= 1'b0;
          dc_done   <= 1'b0;
          mem_we    <= 1'b0;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Beat datapath: same-cycle pass-through so a beat costs no extra latency.
  // Anything arriving outside the matching data phase is dropped.
  // -------------------------------------------------------------------------
  assign rd_data    = (read_phase && mem_rvalid) ? mem_rdata : '0;
  assign ic_rvalid  = read_phase && mem_rvalid && (owner_reg == OWN_I);
  assign dc_rvalid  = read_phase && mem_rvalid && (owner_reg == OWN_D);

  assign mem_wvalid = write_phase;
  assign mem_wdata  = write_phase ? dc_wdata : '0;
  assign dc_wready  = write_phase && mem_wready;

  // Gated with rst_n so every output reads 0 while reset is held.
  assign flush_done = rst_n && flush_req && idle;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed bench: the bench plays both caches and the memory, steps the
// design cycle by cycle and compares outputs against hand-computed values.
// Inputs change 1 ns after each rising edge; combinational outputs are read
// a further 1 ns later.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = '0;
  logic        ic_rvalid;
  logic        ic_done;
  logic        dc_req = 1'b0;
  logic        dc_we = 1'b0;
  logic [31:0] dc_addr = '0;
  logic [31:0] dc_wdata = '0;
  logic        dc_wready;
  logic        dc_rvalid;
  logic        dc_done;
  logic [31:0] rd_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_wdata;
  logic        mem_wvalid;
  logic        mem_wready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        flush_req = 1'b0;
  logic        flush_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ic_req     (ic_req),
    .ic_addr    (ic_addr),
    .ic_rvalid  (ic_rvalid),
    .ic_done    (ic_done),
    .dc_req     (dc_req),
    .dc_we      (dc_we),
    .dc_addr    (dc_addr),
    .dc_wdata   (dc_wdata),
    .dc_wready  (dc_wready),
    .dc_rvalid  (dc_rvalid),
    .dc_done    (dc_done),
    .rd_data    (rd_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_wdata  (mem_wdata),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .flush_req  (flush_req),
    .flush_done (flush_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serve n read beats back to back; beat k carries 0xA000_0000 + base + k.
  task automatic read_beats(input int n, input int base, input logic side_i, input string tag);
    logic [31:0] exp_data;
    for (int i = 0; i < n; i++) begin
      exp_data   = 32'hA000_0000 + 32'(base + i);
      mem_rvalid = 1'b1;
      mem_rdata  = exp_data;
      #1;
      check({tag, "_rv_own"},   32'(side_i ? ic_rvalid : dc_rvalid), 32'd1);
      check({tag, "_rv_other"}, 32'(side_i ? dc_rvalid : ic_rvalid), 32'd0);
      check({tag, "_rdata"},    rd_data, exp_data);
      step();
    end
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  initial begin
    logic [4:0] wr_pat;
    int         accepts;

    // ---------------- reset state ----------------
    flush_req = 1'b1;
    step();
    step();
    #1;
    check("rst_mem_req",    32'(mem_req),    32'd0);
    check("rst_mem_addr",   mem_addr,        32'd0);
    check("rst_mem_wvalid", 32'(mem_wvalid), 32'd0);
    check("rst_done",       32'({ic_done, dc_done}), 32'd0);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    flush_req = 1'b0;

    // ---------------- I-side read burst, gnt after 2 cycles ----------------
    rst_n   = 1'b1;
    ic_req  = 1'b1;
    ic_addr = 32'h0000_0100;
    step();
    check("i_mem_req",  32'(mem_req), 32'd1);
    check("i_mem_addr", mem_addr,     32'h0000_0100);
    check("i_mem_we",   32'(mem_we),  32'd0);
    mem_rvalid = 1'b1;           // stray beat during ADDR must be dropped
    mem_rdata  = 32'hDEAD_BEEF;
    #1;
    check("i_addr_rvalid_ign", 32'(ic_rvalid), 32'd0);
    check("i_addr_rdata_ign",  rd_data,        32'd0);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    step();
    check("i_mem_req_hold", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check("i_mem_req_drop", 32'(mem_req), 32'd0);
    read_beats(4, 0, 1'b1, "i_rd");
    check("i_done",    32'(ic_done), 32'd1);
    check("i_dc_done", 32'(dc_done), 32'd0);
    $display("txn 1: I read  addr=0x%08h beats=4", 32'h0000_0100);
    ic_req = 1'b0;
    step();
    check("i_done_pulse", 32'(ic_done), 32'd0);
    check("i_idle_req",   32'(mem_req), 32'd0);

    // ---------------- D-side write burst, wready 1,0,1,1,1 ----------------
    dc_req  = 1'b1;
    dc_we   = 1'b1;
    dc_addr = 32'h0000_2000;
    step();
    check("d_wr_mem_req",  32'(mem_req), 32'd1);
    check("d_wr_mem_we",   32'(mem_we),  32'd1);
    check("d_wr_mem_addr", mem_addr,     32'h0000_2000);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    wr_pat  = 5'b11101;
    accepts = 0;
    for (int i = 0; i < 5; i++) begin
      mem_wready = wr_pat[i];
      dc_wdata   = 32'hD000_0000 + 32'(i);
      #1;
      check("d_wr_wvalid", 32'(mem_wvalid), 32'd1);
      check("d_wr_wdata",  mem_wdata,       32'hD000_0000 + 32'(i));
      check("d_wr_wready", 32'(dc_wready),  32'(wr_pat[i]));
      if (dc_wready) begin
        accepts++;
      end
      step();
    end
    mem_wready = 1'b0;
    check("d_wr_accepts", 32'(accepts),    32'd4);
    check("d_wr_done",    32'(dc_done),    32'd1);
    check("d_wr_wv_low",  32'(mem_wvalid), 32'd0);
    $display("txn 2: D write addr=0x%08h beats=%0d", 32'h0000_2000, accepts);
    dc_req = 1'b0;
    dc_we  = 1'b0;
    step();
    check("d_wr_done_pulse", 32'(dc_done), 32'd0);

    // ---------------- both requesting: D first, then starved I ----------------
    ic_req  = 1'b1;
    ic_addr = 32'h0000_0300;
    dc_req  = 1'b1;
    dc_addr = 32'h0000_0400;
    step();
    check("st_first_addr", mem_addr, 32'h0000_0400);
    step();
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    read_beats(4, 16, 1'b0, "st_d");
    check("st_d_done", 32'(dc_done), 32'd1);
    $display("txn 3: D read  addr=0x%08h beats=4", 32'h0000_0400);
    step();
    check("st_idle_req", 32'(mem_req), 32'd0);
    step();
    check("st_second_addr", mem_addr,     32'h0000_0300);
    check("st_second_we",   32'(mem_we),  32'd0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    read_beats(4, 32, 1'b1, "st_i");
    check("st_i_done",    32'(ic_done), 32'd1);
    check("st_i_dc_done", 32'(dc_done), 32'd0);
    $display("txn 4: I read  addr=0x%08h beats=4 (after starvation)", 32'h0000_0300);
    ic_req = 1'b0;
    dc_req = 1'b0;
    step();

    // ---------------- flush raised mid-burst ----------------
    ic_req  = 1'b1;
    ic_addr = 32'h0000_0500;
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    read_beats(2, 48, 1'b1, "fl_i");
    flush_req = 1'b1;
    read_beats(2, 50, 1'b1, "fl_i");
    check("fl_i_done",     32'(ic_done),    32'd1);
    check("fl_done_busy",  32'(flush_done), 32'd0);
    $display("txn 5: I read  addr=0x%08h beats=4 (flush pending)", 32'h0000_0500);
    ic_req  = 1'b0;
    dc_req  = 1'b1;
    dc_addr = 32'h0000_0600;
    step();
    #1;
    check("fl_done_idle", 32'(flush_done), 32'd1);
    check("fl_block_0",   32'(mem_req),    32'd0);
    step();
    check("fl_block_1",   32'(mem_req),    32'd0);
    step();
    check("fl_block_2",   32'(mem_req),    32'd0);
    flush_req = 1'b0;
    #1;
    check("fl_done_clear", 32'(flush_done), 32'd0);
    step();
    check("fl_after_req",  32'(mem_req), 32'd1);
    check("fl_after_addr", mem_addr,     32'h0000_0600);

    // ---------------- reset during data beat 2 ----------------
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    read_beats(2, 64, 1'b0, "rs_d");
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    rst_n      = 1'b0;
    #1;
    check("rs_rvalid",  32'(dc_rvalid), 32'd0);
    check("rs_rdata",   rd_data,        32'd0);
    check("rs_mem_req", 32'(mem_req),   32'd0);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    step();
    check("rs_held_done", 32'(dc_done), 32'd0);
    $display("txn 6: D read  addr=0x%08h abandoned by reset", 32'h0000_0600);
    rst_n   = 1'b1;
    dc_addr = 32'h0000_0700;
    step();
    check("rs_regrant_req",  32'(mem_req), 32'd1);
    check("rs_regrant_addr", mem_addr,     32'h0000_0700);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    read_beats(3, 80, 1'b0, "rs_new");
    check("rs_not_done_early", 32'(dc_done), 32'd0);
    read_beats(1, 83, 1'b0, "rs_new");
    check("rs_new_done", 32'(dc_done), 32'd1);
    $display("txn 7: D read  addr=0x%08h beats=4 (after reset)", 32'h0000_0700);
    dc_req = 1'b0;
    step();
    check("rs_final_done", 32'(dc_done), 32'd0);
    check("rs_final_req",  32'(mem_req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter BEATS, default 4, words per burst (power of two, >=1).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, wait cycles after which the I-side wins over the D-side.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port ic_req  in  1  Icache refill request, held until ic_done.
REQ-006 SHALL have port ic_addr  in  32  Icache burst base address.
REQ-007 SHALL have port dc_req  in  1  Dcache refill/writeback request, held until dc_done.
REQ-008 SHALL have port dc_we  in  1  Dcache request is a write (writeback).
REQ-009 SHALL have port dc_addr  in  32  Dcache burst base address.
REQ-010 SHALL have port dc_wdata  in  32  Dcache write beat data.
REQ-011 SHALL have port dc_wready  out  1  current write beat accepted.
REQ-012 SHALL have port rd_data  out  32  read beat data, shared by both sides.
REQ-013 SHALL have port ic_rvalid / dc_rvalid  out  1 each  rd_data valid for that side.
REQ-014 SHALL have port ic_done / dc_done  out  1 each  one-cycle burst-complete pulse.
REQ-015 SHALL have port mem_req  out  1  memory address phase request.
REQ-016 SHALL have port mem_we  out  1  memory burst direction.
REQ-017 SHALL have port mem_addr  out  32  memory burst base address.
REQ-018 SHALL have port mem_gnt  in  1  memory accepts address phase.
REQ-019 SHALL have port mem_wdata  out  32  / mem_wvalid  out  1  write beat.
REQ-020 SHALL have port mem_wready  in  1  memory accepts write beat.
REQ-021 SHALL have port mem_rdata  in  32  / mem_rvalid  in  1  read beat.
REQ-022 SHALL have port flush_req  in  1  CSR memory flush: block new grants.
REQ-023 SHALL have port flush_done  out  1  bus drained while flush_req high.

Function
REQ-024 SHALL implement FSM IDLE, ADDR, DATA, DONE; IDLE->ADDR on grant, ADDR->DATA on mem_gnt, DATA->DONE on final beat, DONE->IDLE unconditionally.
REQ-025 In IDLE with flush_req low: dc_req only -> D; ic_req only -> I; both -> D unless starve_cnt >= STARVE_LIMIT, then I.
REQ-026 starve_cnt SHALL increment (saturating) each cycle ic_req=1 and I is not owner, clear when I is granted.
REQ-027 On grant SHALL register owner, address and we (forced 0 for I); mem_req rises the cycle after the grant decision.
REQ-028 ADDR: mem_req=1 with registered mem_addr/mem_we until mem_gnt; mem_gnt in any other state ignored.
REQ-029 Read DATA: each mem_rvalid passes mem_rdata to rd_data and asserts the owner's rvalid the same cycle (combinational); beat counter increments.
REQ-030 Write DATA: mem_wvalid=1, mem_wdata=dc_wdata, dc_wready=mem_wready; beat advances on mem_wvalid&mem_wready.
REQ-031 Beat counter is clog2(BEATS) bits (1 bit if BEATS=1); the beat at count BEATS-1 moves to DONE, counter wraps to 0.
REQ-032 DONE: owner's done=1 for exactly one cycle; requester drops req the following cycle; no back-to-back grant to the same side without a re-sampled req.
REQ-033 mem_rvalid outside read DATA SHALL be ignored; non-owner rvalid/done stay 0.
REQ-034 flush_req high in IDLE blocks grants; flush_done=1 iff flush_req=1 and state=IDLE; flush_req mid-burst lets the burst complete first.

Reset
REQ-035 rst_n low SHALL asynchronously force IDLE, starve_cnt=0, beat=0, all outputs 0, mid-burst included (burst abandoned).
REQ-036 First grant SHALL be possible the first cycle after rst_n deasserts.

Structure
REQ-037 FSM state encoding, BEATS and STARVE_LIMIT defaults belong in the shared Define.v header.
REQ-038 One sub-module natural: arb_starve_cnt (saturating wait counter); all else flat.

Verification
REQ-039 ic_req alone, addr 0x100, mem_gnt after 2 cycles, 4 rvalids -> mem_addr=0x100, mem_we=0, 4 ic_rvalid, ic_done one cycle after the 4th.
REQ-040 dc_req with dc_we=1, mem_wready toggling 1,0,1,1,1 -> exactly 4 beats, dc_done once, mem_wvalid low after the 4th accept.
REQ-041 ic_req and dc_req held continuously, STARVE_LIMIT=8 -> D granted first, I granted at the next IDLE once starve_cnt>=8.
REQ-042 flush_req raised mid-read burst -> burst completes, flush_done=1 in following IDLE, no new grant while flush_req high.
REQ-043 rst_n pulsed low during DATA beat 2 -> outputs 0 immediately, IDLE after release, fresh request served from beat 0.
